uart_imem_loader: RTL and testbench
===================================

// Module: uart_imem_loader
// PURPOSE
//  Boot-time instruction loader between the UART receiver and the instruction memory.
//  - Assembles received bytes, LSB byte first, into 32-bit words.
//  - Writes each word to consecutive IMEM addresses.
//  - Holds the core in reset until the program is loaded, then raises write_done.
//  - An end marker, a full memory or a UART BREAK sequences the load/reload.
// PARAMETERS
//  ADDR_W       8        IMEM word-address width; depth = 2**ADDR_W words
//  END_WORD     32'hFFFF_FFFF  end-of-program marker; never written to IMEM
//  TIMEOUT_CYC  1000000  idle clk cycles allowed inside a partial word; 0 disables
// PORTS
//  clk          in   1       system clock
//  resetn       in   1       asynchronous active-low reset
//  rx_valid     in   1       1-cycle pulse: rx_data holds a received byte
//  rx_data      in   8       received byte
//  rx_break     in   1       UART BREAK detected (1-cycle pulse)
//  imem_we      out  1       IMEM write strobe, 1 cycle per word
//  imem_addr    out  ADDR_W  IMEM word address
//  imem_wdata   out  32      IMEM write data
//  cpu_rst      out  1       active-high core reset; 1 until load completes
//  write_done   out  1       program loaded, core released
//  load_error   out  1       sticky: partial word discarded (timeout or BREAK)
//  word_count   out  ADDR_W+1  words written in the current load
// BEHAVIOUR
//  Reset (async, resetn=0):
//  - State LOAD; imem_we=0, imem_addr=0, imem_wdata=0.
//  - cpu_rst=1, write_done=0, load_error=0, word_count=0.
//  - Byte index=0; timeout counter=0.
//  States: LOAD (collect bytes), WRITE (strobe), DONE (core running). All outputs are registered.
//  LOAD:
//  - Byte k (k=0..3) of a word goes to wdata[8k+7:8k].
//  - On the 4th byte:
//    - word != END_WORD -> WRITE.
//    - word == END_WORD -> DONE, with no write.
//  WRITE:
//  - imem_we=1 for exactly 1 cycle with imem_addr/imem_wdata stable.
//  - Latency: 4th rx_valid in cycle N -> imem_we=1 in cycle N+1.
//  - Next cycle: addr+1, word_count+1, return to LOAD.
//  - If that write used addr 2**ADDR_W-1 -> DONE instead. Addr does not wrap; later bytes are ignored.
//  - A byte on rx_valid during WRITE is captured as byte 0 of the next word. No byte is ever dropped.
//  DONE:
//  - write_done=1 and cpu_rst=0, both in the cycle after entry.
//  - rx_valid is ignored; imem_we stays 0.
//  Timeout:
//  - The counter runs only while byte index != 0 in LOAD.
//  - It clears on every rx_valid.
//  - At TIMEOUT_CYC: discard the partial word, byte index=0, load_error=1. Addr is unchanged.
//  rx_break:
//  - In LOAD/WRITE: discard the partial word (load_error=1 if index != 0), addr=0, word_count=0.
//    - A WRITE in progress completes first.
//  - In DONE: reload. Next cycle cpu_rst=1, write_done=0, addr=0, word_count=0, state LOAD.
//    - load_error is cleared on entry to reload.
//  - If rx_break and rx_valid arrive in the same cycle, rx_break wins and the byte is dropped.
//  - load_error clears only on reset or on a BREAK reload from DONE.
// TESTING
//  1. Send bytes 13 01 01 F9 -> one imem_we, addr 0, wdata F9010113, 1 cycle after the 4th rx_valid.
//  2. Send 3 words, then FF FF FF FF -> addrs 0,1,2 written; no 4th write.
//     Next cycle write_done=1, cpu_rst=0, word_count=3.
//  3. ADDR_W=2, send 5 words -> 4 writes (addr 0..3), DONE after the 4th; 5th word ignored, no wrap.
//  4. TIMEOUT_CYC=100, send 2 bytes, idle 100 cycles -> load_error=1, no write.
//     Then 4 bytes AA BB CC DD -> wdata DDCCBBAA at the same addr.
//  5. In DONE, pulse rx_break -> cpu_rst=1, write_done=0, addr=0.
//     Reload of 1 word + END_WORD -> write_done=1.
//  6. Assert resetn=0 mid-word (2 bytes in) -> all outputs at reset values.
//     Next 4 bytes form a word written at addr 0.

Source files
------------

// File: rtl/uart_imem_loader_if.sv
// Signal bundle between the UART receiver/IMEM side and the boot loader.
// rx_valid is a one-cycle strobe with no ready: the loader accepts every byte it is offered.
interface uart_imem_loader_if #(
   parameter int ADDR_W = 8
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_break;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_rst;
   logic              write_done;
   logic              load_error;
   logic [ADDR_W:0]   word_count;
   logic [1:0]        dbg_state;

   modport slave (
      input  rx_valid, rx_data, rx_break,
      output imem_we, imem_addr, imem_wdata, cpu_rst, write_done,
      output load_error, word_count, dbg_state
   );

   modport master (
      output rx_valid, rx_data, rx_break,
      input  imem_we, imem_addr, imem_wdata, cpu_rst, write_done,
      input  load_error, word_count, dbg_state
   );
endinterface

// File: rtl/uart_imem_loader.sv
// Boot loader: packs UART bytes (LSB first) into 32-bit words, writes them to IMEM,
// and holds the core in reset until an end marker, a full memory, or a BREAK sequences it.
module uart_imem_loader #(
   parameter int          ADDR_W      = 8,
   parameter logic [31:0] END_WORD    = 32'hFFFF_FFFF,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic clk,
   input  logic resetn,
   uart_imem_loader_if.slave bus
);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [31:0]       TO_LAST  = TIMEOUT_CYC - 1;
   localparam logic [ADDR_W:0]   WC_ONE   = 1;
   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   state_t            r_state,      w_state_nxt;
   logic [1:0]        r_idx,        w_idx_nxt;
   logic [23:0]       r_buf,        w_buf_nxt;
   logic              r_we,         w_we_nxt;
   logic [ADDR_W-1:0] r_addr,       w_addr_nxt;
   logic [31:0]       r_wdata,      w_wdata_nxt;
   logic              r_cpu_rst,    w_cpu_rst_nxt;
   logic              r_done,       w_done_nxt;
   logic              r_err,        w_err_nxt;
   logic [ADDR_W:0]   r_wc,         w_wc_nxt;
   logic [31:0]       r_cnt,        w_cnt_nxt;
   logic [31:0]       w_word;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_LOAD;
         r_idx     <= 2'd0;
         r_buf     <= 24'd0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= 32'd0;
         r_cpu_rst <= 1'b1;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_wc      <= '0;
         r_cnt     <= 32'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_buf     <= w_buf_nxt;
         r_we      <= w_we_nxt;
         r_addr    <= w_addr_nxt;
         r_wdata   <= w_wdata_nxt;
         r_cpu_rst <= w_cpu_rst_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
         r_wc      <= w_wc_nxt;
         r_cnt     <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_buf_nxt     = r_buf;
      w_we_nxt      = 1'b0;
      w_addr_nxt    = r_addr;
      w_wdata_nxt   = r_wdata;
      w_cpu_rst_nxt = r_cpu_rst;
      w_done_nxt    = r_done;
      w_err_nxt     = r_err;
      w_wc_nxt      = r_wc;
      w_cnt_nxt     = r_cnt;
      w_word        = {bus.rx_data, r_buf};

      unique case (r_state)
         S_LOAD: begin
            if (bus.rx_break) begin
               // BREAK beats a same-cycle byte; only a half-built word counts as an error.
               w_idx_nxt  = 2'd0;
               w_cnt_nxt  = 32'd0;
               w_addr_nxt = '0;
               w_wc_nxt   = '0;
               if (r_idx != 2'd0) w_err_nxt = 1'b1;
            end else if (bus.rx_valid) begin
               w_cnt_nxt = 32'd0;
               unique case (r_idx)
                  2'd0: w_buf_nxt[7:0]   = bus.rx_data;
                  2'd1: w_buf_nxt[15:8]  = bus.rx_data;
                  2'd2: w_buf_nxt[23:16] = bus.rx_data;
                  default: ;
               endcase
               if (r_idx == 2'd3) begin
                  w_idx_nxt = 2'd0;
                  if (w_word == END_WORD) begin
                     w_state_nxt   = S_DONE;
                     w_done_nxt    = 1'b1;
                     w_cpu_rst_nxt = 1'b0;
                  end else begin
                     w_state_nxt = S_WRITE;
                     w_we_nxt    = 1'b1;
                     w_wdata_nxt = w_word;
                  end
               end else begin
                  w_idx_nxt = r_idx + 2'd1;
               end
            end else if ((TIMEOUT_CYC != 0) && (r_idx != 2'd0)) begin
               if (r_cnt == TO_LAST) begin
                  w_idx_nxt = 2'd0;
                  w_cnt_nxt = 32'd0;
                  w_err_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + 32'd1;
               end
            end
         end

         S_WRITE: begin
            // The strobe is already on the bus this cycle, so the write always lands.
            w_cnt_nxt = 32'd0;
            if (bus.rx_break) begin
               w_state_nxt = S_LOAD;
               w_idx_nxt   = 2'd0;
               w_addr_nxt  = '0;
               w_wc_nxt    = '0;
            end else begin
               w_wc_nxt = r_wc + WC_ONE;
               if (r_addr == ADDR_MAX) begin
                  w_state_nxt   = S_DONE;
                  w_done_nxt    = 1'b1;
                  w_cpu_rst_nxt = 1'b0;
               end else begin
                  w_state_nxt = S_LOAD;
                  w_addr_nxt  = r_addr + ADDR_ONE;
                  if (bus.rx_valid) begin
                     w_buf_nxt[7:0] = bus.rx_data;
                     w_idx_nxt      = 2'd1;
                  end
               end
            end
         end

         S_DONE: begin
            if (bus.rx_break) begin
               w_state_nxt   = S_LOAD;
               w_cpu_rst_nxt = 1'b1;
               w_done_nxt    = 1'b0;
               w_addr_nxt    = '0;
               w_wc_nxt      = '0;
               w_err_nxt     = 1'b0;
               w_idx_nxt     = 2'd0;
               w_cnt_nxt     = 32'd0;
            end
         end

         default: w_state_nxt = S_LOAD;
      endcase
   end

   assign bus.imem_we    = r_we;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = r_wdata;
   assign bus.cpu_rst    = r_cpu_rst;
   assign bus.write_done = r_done;
   assign bus.load_error = r_err;
   assign bus.word_count = r_wc;
   assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench: a large-memory loader (100-cycle timeout) and a 4-word loader driven
// from one linear sequence, with negedge write monitors against expected-write queues.
module tb_uart_imem_loader;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [39:0] exp_qa[$];
   logic [39:0] exp_qb[$];

   uart_imem_loader_if #(.ADDR_W(8)) bus_a ();
   uart_imem_loader_if #(.ADDR_W(2)) bus_b ();

   uart_imem_loader #(.ADDR_W(8), .END_WORD(32'hFFFF_FFFF), .TIMEOUT_CYC(100)) dut_a (
      .clk(clk), .resetn(resetn), .bus(bus_a.slave)
   );
   uart_imem_loader #(.ADDR_W(2), .END_WORD(32'hFFFF_FFFF), .TIMEOUT_CYC(0)) dut_b (
      .clk(clk), .resetn(resetn), .bus(bus_b.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input bit sel, input logic [7:0] b);
      if (!sel) begin
         bus_a.rx_valid = 1'b1; bus_a.rx_data = b;
      end else begin
         bus_b.rx_valid = 1'b1; bus_b.rx_data = b;
      end
      @(posedge clk); #1;
      bus_a.rx_valid = 1'b0;
      bus_b.rx_valid = 1'b0;
   endtask

   task automatic send_word(input bit sel, input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(sel, w[8*k +: 8]);
   endtask

   task automatic pulse_break();
      bus_a.rx_break = 1'b1;
      @(posedge clk); #1;
      bus_a.rx_break = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Write monitors: every strobe must match the next expected {addr, data}.
   always @(negedge clk) begin
      if (bus_a.imem_we === 1'b1) begin
         if (exp_qa.size() == 0) chk("write_a_unexpected", {8'd0, bus_a.imem_addr, bus_a.imem_wdata}, 64'hDEAD);
         else chk("write_a", {24'd0, bus_a.imem_addr, bus_a.imem_wdata}, {24'd0, exp_qa.pop_front()});
      end
      if (bus_b.imem_we === 1'b1) begin
         if (exp_qb.size() == 0) chk("write_b_unexpected", {30'd0, bus_b.imem_addr, bus_b.imem_wdata}, 64'hDEAD);
         else chk("write_b", {30'd0, bus_b.imem_addr, bus_b.imem_wdata}, {24'd0, exp_qb.pop_front()});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus_a.rx_valid = 1'b0; bus_a.rx_data = 8'd0; bus_a.rx_break = 1'b0;
      bus_b.rx_valid = 1'b0; bus_b.rx_data = 8'd0; bus_b.rx_break = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_we",     bus_a.imem_we,    0);
      chk("rst_addr",   bus_a.imem_addr,  0);
      chk("rst_wdata",  bus_a.imem_wdata, 0);
      chk("rst_cpu",    bus_a.cpu_rst,    1);
      chk("rst_done",   bus_a.write_done, 0);
      chk("rst_err",    bus_a.load_error, 0);
      chk("rst_wc",     bus_a.word_count, 0);
      chk("rst_state",  bus_a.dbg_state,  0);
      resetn = 1'b1;
      idle(1);

      // Small memory: 5 words, only addresses 0..3 written, no wrap
      exp_qb.push_back({8'd0, 32'h1111_1111});
      exp_qb.push_back({8'd1, 32'h2222_2222});
      exp_qb.push_back({8'd2, 32'h3333_3333});
      exp_qb.push_back({8'd3, 32'h4444_4444});
      send_word(1, 32'h1111_1111);
      send_word(1, 32'h2222_2222);
      send_word(1, 32'h3333_3333);
      send_word(1, 32'h4444_4444);
      send_word(1, 32'h5555_5555);
      idle(2);
      chk("full_done",  bus_b.write_done, 1);
      chk("full_cpu",   bus_b.cpu_rst,    0);
      chk("full_wc",    bus_b.word_count, 4);
      chk("full_addr",  bus_b.imem_addr,  3);
      chk("full_q",     exp_qb.size(),    0);

      // Single word: strobe one cycle after the 4th byte
      exp_qa.push_back({8'd0, 32'hF901_0113});
      send_byte(0, 8'h13);
      send_byte(0, 8'h01);
      send_byte(0, 8'h01);
      chk("w1_no_early_we", bus_a.imem_we, 0);
      send_byte(0, 8'hF9);
      chk("w1_we",      bus_a.imem_we,    1);
      chk("w1_addr",    bus_a.imem_addr,  0);
      chk("w1_wdata",   bus_a.imem_wdata, 32'hF901_0113);
      chk("w1_state",   bus_a.dbg_state,  1);
      idle(1);
      chk("w1_we_off",  bus_a.imem_we,    0);
      chk("w1_addr_inc", bus_a.imem_addr, 1);
      chk("w1_wc",      bus_a.word_count, 1);

      // Back-to-back words then end marker
      exp_qa.push_back({8'd1, 32'h0050_0093});
      exp_qa.push_back({8'd2, 32'h00A0_0113});
      send_word(0, 32'h0050_0093);
      send_word(0, 32'h00A0_0113);
      send_word(0, 32'hFFFF_FFFF);
      chk("end_done",   bus_a.write_done, 1);
      chk("end_cpu",    bus_a.cpu_rst,    0);
      chk("end_wc",     bus_a.word_count, 3);
      chk("end_state",  bus_a.dbg_state,  2);
      send_word(0, 32'h1234_5678);
      idle(2);
      chk("done_ignore_wc", bus_a.word_count, 3);
      chk("done_ignore_q",  exp_qa.size(),    0);

      // BREAK in DONE reloads
      pulse_break();
      chk("rl_cpu",     bus_a.cpu_rst,    1);
      chk("rl_done",    bus_a.write_done, 0);
      chk("rl_addr",    bus_a.imem_addr,  0);
      chk("rl_wc",      bus_a.word_count, 0);
      chk("rl_state",   bus_a.dbg_state,  0);
      exp_qa.push_back({8'd0, 32'h0000_0013});
      send_word(0, 32'h0000_0013);
      send_word(0, 32'hFFFF_FFFF);
      chk("rl_done2",   bus_a.write_done, 1);
      chk("rl_wc2",     bus_a.word_count, 1);

      // Timeout on a partial word, exactly at 100 idle cycles
      pulse_break();
      send_byte(0, 8'h11);
      send_byte(0, 8'h22);
      idle(99);
      chk("to_before",  bus_a.load_error, 0);
      idle(1);
      chk("to_err",     bus_a.load_error, 1);
      chk("to_addr",    bus_a.imem_addr,  0);
      idle(5);
      exp_qa.push_back({8'd0, 32'hDDCC_BBAA});
      send_word(0, 32'hDDCC_BBAA);
      idle(1);
      chk("to_addr2",   bus_a.imem_addr,  1);
      chk("to_sticky",  bus_a.load_error, 1);

      // BREAK mid-word in LOAD
      send_byte(0, 8'h55);
      pulse_break();
      chk("brk_addr",   bus_a.imem_addr,  0);
      chk("brk_wc",     bus_a.word_count, 0);
      chk("brk_err",    bus_a.load_error, 1);

      // BREAK and byte together: byte dropped
      bus_a.rx_valid = 1'b1; bus_a.rx_data = 8'h99; bus_a.rx_break = 1'b1;
      @(posedge clk); #1;
      bus_a.rx_valid = 1'b0; bus_a.rx_break = 1'b0;
      exp_qa.push_back({8'd0, 32'h4433_2211});
      send_word(0, 32'h4433_2211);
      idle(1);
      chk("drop_addr",  bus_a.imem_addr,  1);

      // load_error clears on reload from DONE
      send_word(0, 32'hFFFF_FFFF);
      chk("clr_done",   bus_a.write_done, 1);
      chk("clr_err_pre", bus_a.load_error, 1);
      pulse_break();
      chk("clr_err",    bus_a.load_error, 0);

      // Async reset mid-word
      exp_qa.push_back({8'd0, 32'h0000_0033});
      send_word(0, 32'h0000_0033);
      send_byte(0, 8'h01);
      send_byte(0, 8'h02);
      #2 resetn = 1'b0;
      #1;
      chk("ar_we",      bus_a.imem_we,    0);
      chk("ar_addr",    bus_a.imem_addr,  0);
      chk("ar_wdata",   bus_a.imem_wdata, 0);
      chk("ar_cpu",     bus_a.cpu_rst,    1);
      chk("ar_done",    bus_a.write_done, 0);
      chk("ar_wc",      bus_a.word_count, 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      idle(1);
      exp_qa.push_back({8'd0, 32'hA0B0_C0D0});
      send_word(0, 32'hA0B0_C0D0);
      idle(1);
      chk("ar_addr2",   bus_a.imem_addr,  1);
      chk("ar_wc2",     bus_a.word_count, 1);

      idle(3);
      chk("final_qa",   exp_qa.size(), 0);
      chk("final_qb",   exp_qb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
